// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode decoder and its event FIFO.
package ps2_pkg;

  localparam int FRAME_W = 11;
  localparam int START_B = 10;
  localparam int D0_B    = 9;
  localparam int PAR_B   = 1;
  localparam int STOP_B  = 0;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_event_t;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } dec_state_t;

  // Data bits arrive LSB first, so d0 sits at the highest data index.
  function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] f);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = f[D0_B-i];
    end
    return b;
  endfunction

  function automatic logic frame_ok(input logic [FRAME_W-1:0] f);
    return !f[START_B] && f[STOP_B] && (^f[D0_B:PAR_B]);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; depth must be a power of two.
module sync_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A write into a full FIFO is only accepted when a read frees a slot in the same cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Validates captured PS/2 frames, folds E0/F0 prefixes into key events and
// queues them for a valid/ready consumer.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [10:0]        frame_i,
  input  logic               frame_valid_i,
  output logic               key_valid_o,
  input  logic               key_ready_i,
  output logic [7:0]         key_code_o,
  output logic               key_ext_o,
  output logic               key_rel_o,
  output logic               frame_err_o,
  output logic               overflow_o,
  output logic [ERR_W-1:0]   err_count_o
);

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                               input logic [1:0]       b);
    logic [ERR_W:0] s;
    s = {1'b0, a} + {{(ERR_W-1){1'b0}}, b};
    return s[ERR_W] ? {ERR_W{1'b1}} : s[ERR_W-1:0];
  endfunction

  logic       vld_p1;
  logic [7:0] byte_p1;
  logic       ok_p1;

  dec_state_t state;
  key_event_t push_ev;
  key_event_t head;
  logic       push;
  logic       pop;
  logic       is_prefix;
  logic       fifo_full;
  logic       fifo_empty;
  logic       err_now;
  logic       drop_now;
  logic [1:0] err_inc;

  // ---- stage 1: capture byte and frame check ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= frame_valid_i;
  end

  always_ff @(posedge clk) begin
    if (frame_valid_i) begin
      byte_p1 <= frame_byte(frame_i);
      ok_p1   <= frame_ok(frame_i);
    end
  end

  // ---- stage 2: prefix folding, FIFO push, error accounting ----
  assign is_prefix = (byte_p1 == PS2_EXT) || (byte_p1 == PS2_BRK);
  assign err_now   = vld_p1 && !ok_p1;

  always_comb begin
    push         = 1'b0;
    push_ev      = '0;
    push_ev.code = byte_p1;
    if (vld_p1 && ok_p1 && !is_prefix) begin
      push        = 1'b1;
      push_ev.ext = (state == EXT) || (state == EXT_BRK);
      push_ev.rel = (state == BRK) || (state == EXT_BRK);
    end
  end

  assign pop      = !fifo_empty && key_ready_i;
  assign drop_now = push && fifo_full && !pop;
  assign err_inc  = {1'b0, err_now} + {1'b0, drop_now};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
      err_count_o <= '0;
    end else begin
      frame_err_o <= err_now;
      overflow_o  <= drop_now;
      err_count_o <= sat_add(err_count_o, err_inc);
      if (err_now) begin
        state <= IDLE;
      end else if (vld_p1) begin
        case (state)
          IDLE: begin
            if (byte_p1 == PS2_EXT)      state <= EXT;
            else if (byte_p1 == PS2_BRK) state <= BRK;
          end
          EXT: begin
            if (byte_p1 == PS2_BRK)      state <= EXT_BRK;
            else if (byte_p1 != PS2_EXT) state <= IDLE;
          end
          BRK: begin
            if (byte_p1 == PS2_EXT)      state <= EXT_BRK;
            else if (byte_p1 != PS2_BRK) state <= IDLE;
          end
          EXT_BRK: begin
            if (!is_prefix) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  sync_fifo #(
    .DATA_W ($bits(key_event_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_event_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_ev),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head fields read as zero whenever nothing is queued.
  assign key_valid_o = !fifo_empty;
  assign key_code_o  = fifo_empty ? 8'h00 : head.code;
  assign key_ext_o   = fifo_empty ? 1'b0  : head.ext;
  assign key_rel_o   = fifo_empty ? 1'b0  : head.rel;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomised and directed bench for ps2_scancode_decoder against a queue-based event model.
module tb_ps2_scancode_decoder;

  localparam int DEPTH   = 4;
  localparam int EW      = 4;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [10:0]   frame = '0;
  logic          frame_valid = 1'b0;
  logic          key_ready = 1'b0;
  logic          key_valid;
  logic [7:0]    key_code;
  logic          key_ext;
  logic          key_rel;
  logic          frame_err;
  logic          overflow;
  logic [EW-1:0] err_count;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .ERR_W(EW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_i       (frame),
    .frame_valid_i (frame_valid),
    .key_valid_o   (key_valid),
    .key_ready_i   (key_ready),
    .key_code_o    (key_code),
    .key_ext_o     (key_ext),
    .key_rel_o     (key_rel),
    .frame_err_o   (frame_err),
    .overflow_o    (overflow),
    .err_count_o   (err_count)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: queued events {code,ext,rel}, pending prefix flags,
  // the frame waiting one cycle in the pipeline, and the error tally.
  logic [9:0] q[$];
  logic       m_ext, m_rel;
  logic       pend_v, pend_ok;
  logic [7:0] pend_b;
  int         m_err;
  logic       exp_ferr, exp_ovf;

  logic [12+EW:0] obs_vec;
  assign obs_vec = {key_valid, key_code, key_ext, key_rel, frame_err, overflow, err_count};

  function automatic logic [12+EW:0] model_vec();
    logic [9:0] h;
    h = (q.size() > 0) ? q[0] : 10'h0;
    return {(q.size() > 0), h, exp_ferr, exp_ovf, EW'(m_err)};
  endfunction

  // kind: 0 good, 1 parity flipped, 2 stop=0, 3 start=1
  function automatic logic [10:0] make_frame(input logic [7:0] b, input int kind);
    logic [10:0] f;
    f[10] = (kind == 3);
    for (int i = 0; i < 8; i++) f[9-i] = b[i];
    f[1] = (~^b) ^ (kind == 1);
    f[0] = (kind != 2);
    return f;
  endfunction

  function automatic logic [7:0] rand_code();
    logic [7:0] c;
    c = 8'($urandom_range(0, 255));
    while (c == 8'hE0 || c == 8'hF0) c = 8'($urandom_range(0, 255));
    return c;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ext = 1'b0; m_rel = 1'b0;
    pend_v = 1'b0; pend_ok = 1'b0; pend_b = 8'h00;
    m_err = 0; exp_ferr = 1'b0; exp_ovf = 1'b0;
  endtask

  // Called at a falling edge: drive inputs, advance the model across the next
  // rising edge, and return at the following falling edge.
  task automatic step(input logic fv, input logic [7:0] b, input int kind, input logic rdy);
    logic pop, push, err, drop;
    logic [9:0] ev;
    frame_valid = fv;
    frame       = fv ? make_frame(b, kind) : 11'h0;
    key_ready   = rdy;
    pop = (q.size() > 0) && rdy;
    push = 1'b0; err = 1'b0; drop = 1'b0; ev = '0;
    if (pend_v) begin
      if (!pend_ok) begin
        err = 1'b1; m_ext = 1'b0; m_rel = 1'b0;
      end else if (pend_b == 8'hE0) begin
        m_ext = 1'b1;
      end else if (pend_b == 8'hF0) begin
        m_rel = 1'b1;
      end else begin
        ev = {pend_b, m_ext, m_rel};
        m_ext = 1'b0; m_rel = 1'b0;
        if (q.size() < DEPTH || pop) push = 1'b1;
        else drop = 1'b1;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(ev);
    m_err = m_err + int'(err) + int'(drop);
    if (m_err > ERR_MAX) m_err = ERR_MAX;
    pend_v = fv; pend_b = b; pend_ok = (kind == 0);
    exp_ferr = err; exp_ovf = drop;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs_vec !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", obs_vec);
    end
    rst_n = 1'b1;
    step(0, 8'h00, 0, 0);
    checks++;
    if (obs_vec !== model_vec()) begin
      failures++;
      $display("FAIL reset_idle: got %h want %h", obs_vec, model_vec());
    end
  endtask

  task automatic test_single_event();
    step(1, 8'h1C, 0, 1);
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_latency_early: key_valid=%b want 0", key_valid);
    end
    step(0, 8'h00, 0, 1);
    checks++;
    if ({key_valid, key_code, key_ext, key_rel} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL single_event: got v=%b code=%h ext=%b rel=%b want 1 1c 0 0",
               key_valid, key_code, key_ext, key_rel);
    end
    step(0, 8'h00, 0, 1);
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_one_cycle: key_valid=%b want 0", key_valid);
    end
  endtask

  task automatic test_prefix_fold();
    logic [7:0] seq [5] = '{8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h1C};
    for (int i = 0; i < 3; i++) step(1, seq[i], 0, 0);
    step(0, 8'h00, 0, 0);
    checks++;
    if ({key_valid, key_code, key_ext, key_rel} !== {1'b1, 8'h75, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL prefix_ext_brk: got v=%b code=%h ext=%b rel=%b want 1 75 1 1",
               key_valid, key_code, key_ext, key_rel);
    end
    step(0, 8'h00, 0, 1);
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL prefix_single_event: key_valid=%b want 0", key_valid);
    end
    for (int i = 3; i < 5; i++) step(1, seq[i], 0, 0);
    step(0, 8'h00, 0, 0);
    checks++;
    if ({key_valid, key_code, key_ext, key_rel} !== {1'b1, 8'h1C, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL prefix_brk: got v=%b code=%h ext=%b rel=%b want 1 1c 0 1",
               key_valid, key_code, key_ext, key_rel);
    end
    step(0, 8'h00, 0, 1);
    checks++;
    if (obs_vec !== model_vec()) begin
      failures++;
      $display("FAIL prefix_model: got %h want %h", obs_vec, model_vec());
    end
  endtask

  task automatic test_frame_errors();
    int pulses = 0;
    int base;
    base = int'(err_count);
    for (int k = 1; k <= 3; k++) begin
      step(1, 8'h1C, k, 0);
      if (frame_err === 1'b1) pulses++;
    end
    for (int k = 0; k < 2; k++) begin
      step(0, 8'h00, 0, 0);
      if (frame_err === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 3 || int'(err_count) != base + 3 || key_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_errors: pulses=%0d cnt=%0d valid=%b want 3 %0d 0",
               pulses, err_count, key_valid, base + 3);
    end
    step(1, 8'hE0, 0, 0);
    step(1, 8'h00, 1, 0);
    step(1, 8'h75, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    checks++;
    if ({key_valid, key_code, key_ext, key_rel} !== {1'b1, 8'h75, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL error_drops_prefix: got v=%b code=%h ext=%b rel=%b want 1 75 0 0",
               key_valid, key_code, key_ext, key_rel);
    end
    step(0, 8'h00, 0, 1);
    checks++;
    if (obs_vec !== model_vec()) begin
      failures++;
      $display("FAIL errors_model: got %h want %h", obs_vec, model_vec());
    end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    int ovf = 0;
    int base;
    base = int'(err_count);
    for (int i = 0; i < 5; i++) codes[i] = rand_code();
    for (int i = 0; i < 5; i++) begin
      step(1, codes[i], 0, 0);
      if (overflow === 1'b1) ovf++;
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 8'h00, 0, 0);
      if (overflow === 1'b1) ovf++;
    end
    checks++;
    if (ovf != 1 || int'(err_count) != base + 1) begin
      failures++;
      $display("FAIL overflow_pulse: pulses=%0d cnt=%0d want 1 %0d", ovf, err_count, base + 1);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (key_valid !== 1'b1 || key_code !== codes[i]) begin
        failures++;
        $display("FAIL overflow_order[%0d]: v=%b code=%h want 1 %h", i, key_valid, key_code, codes[i]);
      end
      step(0, 8'h00, 0, 1);
    end
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL overflow_drained: key_valid=%b want 0", key_valid);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] codes [5];
    int ovf = 0;
    for (int i = 0; i < 5; i++) codes[i] = rand_code();
    for (int i = 0; i < 5; i++) begin
      step(1, codes[i], 0, 0);
      if (overflow === 1'b1) ovf++;
    end
    step(0, 8'h00, 0, 1);
    if (overflow === 1'b1) ovf++;
    checks++;
    if (ovf != 0 || obs_vec !== model_vec()) begin
      failures++;
      $display("FAIL full_push_pop: ovf=%0d got %h want %h", ovf, obs_vec, model_vec());
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (key_valid !== 1'b1 || key_code !== codes[i]) begin
        failures++;
        $display("FAIL full_push_pop_order[%0d]: v=%b code=%h want 1 %h", i, key_valid, key_code, codes[i]);
      end
      step(0, 8'h00, 0, 1);
    end
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_push_pop_count: key_valid=%b want 0", key_valid);
    end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) step(1, rand_code(), 0, 1);
      else step(0, 8'h00, 0, 1);
      if (key_valid === 1'b1) seen++;
      checks++;
      if (obs_vec !== model_vec()) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, obs_vec, model_vec());
      end
    end
    checks++;
    if (seen != 6) begin
      failures++;
      $display("FAIL back_to_back_count: events=%0d want 6", seen);
    end
  endtask

  task automatic test_reset_mid();
    step(1, rand_code(), 0, 0);
    step(1, rand_code(), 0, 0);
    step(1, 8'hE0, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h want 0", obs_vec);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h1C, 0, 0);
    step(0, 8'h00, 0, 0);
    checks++;
    if ({key_valid, key_code, key_ext, key_rel} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_event: got v=%b code=%h ext=%b rel=%b want 1 1c 0 0",
               key_valid, key_code, key_ext, key_rel);
    end
    step(0, 8'h00, 0, 1);
    checks++;
    if (obs_vec !== model_vec()) begin
      failures++;
      $display("FAIL reset_mid_model: got %h want %h", obs_vec, model_vec());
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < ERR_MAX + 5; i++) step(1, rand_code(), int'($urandom_range(1, 3)), 0);
    step(0, 8'h00, 0, 0);
    checks++;
    if (err_count !== EW'(ERR_MAX) || obs_vec !== model_vec()) begin
      failures++;
      $display("FAIL err_saturate: cnt=%0d want %0d", err_count, ERR_MAX);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int kind;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      kind = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      step(1'($urandom_range(0, 1)), b, kind, 1'($urandom_range(0, 1)));
      checks++;
      if (obs_vec !== model_vec()) begin
        failures++;
        $display("FAIL random[%0d]: got %h want %h", i, obs_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_prefix_fold();
    test_frame_errors();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Downstream consumer of the 11-bit PS/2 frame shift register. Takes each captured frame, checks start/parity/stop, extracts the scancode byte, and folds E0 (extended) and F0 (break) prefixes into a single key event. Events are buffered in a small FIFO and handed to the game/display logic over a valid/ready interface.

Parameters:
FIFO_DEPTH, 4, number of buffered key events; power of two, minimum 2
ERR_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
frame_i  in  11  captured frame; bit 10 = start, bits 9..2 = d0..d7, bit 1 = parity, bit 0 = stop
frame_valid_i  in  1  one-cycle strobe; frame_i is valid in that cycle
key_valid_o  out  1  FIFO head holds an event
key_ready_i  in  1  consumer accepts the head event when key_valid_o is high
key_code_o  out  8  scancode of the head event
key_ext_o  out  1  head event was E0-prefixed
key_rel_o  out  1  head event was F0-prefixed (key release)
frame_err_o  out  1  one-cycle pulse when a frame fails its checks
overflow_o  out  1  one-cycle pulse when an event is dropped because the FIFO is full
err_count_o  out  ERR_W  saturating count of frame errors plus overflows

Behaviour:
- Reset (async, rst_n low): FSM to IDLE; FIFO empty; key_valid_o=0; key_code_o=0, key_ext_o=0, key_rel_o=0; frame_err_o=0; overflow_o=0; err_count_o=0. Reset mid-frame or mid-prefix discards everything.
- Stage 1 (edge where frame_valid_i=1): register the byte and an ok flag.
  - byte = {frame_i[2],frame_i[3],...,frame_i[9]}, i.e. d7..d0 with d0 = frame_i[9].
  - ok = (frame_i[10]==0) and (frame_i[0]==1) and (^frame_i[9:1] == 1), odd parity.
- Stage 2 (next edge): handle the byte.
  - ok=0: frame_err_o pulses in this cycle. err_count_o increments and saturates at all-ones. FSM goes to IDLE and pending prefixes are discarded. No event is produced.
  - ok=1: run the FSM.
- FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> push {byte,0,0}, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> push {byte,1,0}, go IDLE.
  - BRK: E0 -> EXT_BRK; F0 -> stay BRK; other -> push {byte,0,1}, go IDLE.
  - EXT_BRK: E0 or F0 -> stay; other -> push {byte,1,1}, go IDLE.
  - All other bytes (E1, AA, FA, ...) are ordinary codes.
- Latency: frame_valid_i in cycle N with the FIFO empty gives key_valid_o=1 in cycle N+2.
- Throughput: frame_valid_i may assert every cycle; the pipeline never stalls.
- FIFO: first-word-fall-through; head fields are valid whenever key_valid_o=1. Pop occurs when key_valid_o and key_ready_i are both high.
  - Push while full without a pop: the new event is dropped, overflow_o pulses, err_count_o increments (saturating).
  - Push and pop in the same cycle while full: both happen; no overflow.
  - Push into an empty FIFO with key_ready_i=1: the event still appears for at least one cycle; no bypass.
  - key_ready_i while empty: ignored.
- Frame error and overflow in the same cycle: err_count_o increments by 2, saturating.
- Head outputs hold their value while key_valid_o=1 and key_ready_i=0.

Decomposition:
- Package ps2_pkg:
  - key_event_t packed struct {code[7:0], ext, rel}.
  - Constants PS2_EXT=8'hE0, PS2_BRK=8'hF0.
  - Frame index constants START_B=10, PAR_B=1, STOP_B=0.
  - FSM enum dec_state_t.
- One sub-module: sync_fifo, parameterised on width and depth, with full/empty outputs. It is reused for the keyboard-to-display path.

Test Plan:
- Frame for 0x1C (start 0, d0..d7 = 0,0,1,1,1,0,0,0, parity 0, stop 1), key_ready_i=1 -> key_valid_o high 2 cycles later with code 0x1C, ext=0, rel=0, high for exactly 1 cycle.
- Frames E0, F0, 0x75 -> exactly one event {0x75, ext=1, rel=1}. Sequence F0, 0x1C -> {0x1C, 0, 1}.
- 0x1C frame with parity flipped, then stop=0, then start=1 -> frame_err_o pulses 3 times, err_count_o=3, no events. A following E0 then bad frame then 0x75 -> event {0x75,0,0}, confirming the prefix was discarded.
- key_ready_i=0, 5 valid frames with FIFO_DEPTH=4 -> 4 events retained in order, overflow_o pulses once, err_count_o=1. Then key_ready_i=1 -> 4 pops in order.
- FIFO full, push and pop in the same cycle -> no overflow, count stays 4, order preserved. Back-to-back frame_valid_i strobes on consecutive cycles -> all events captured.
- rst_n low for one cycle after an E0 with 2 events queued -> all outputs 0. Next frame 0x1C -> event {0x1C,0,0}.
